led_speed_ctrl: RTL and testbench



---
 rtl/led_speed_ctrl_pkg.sv | 13 +
 rtl/led_speed_ctrl_if.sv | 27 ++
 rtl/led_speed_ctrl_sd_debounce.sv | 50 +++++
 rtl/led_speed_ctrl.sv | 139 +++++++++++++
 tb/tb_led_speed_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_speed_ctrl_pkg.sv
// Shared types and constants for the LED shift-rate controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    localparam logic SPEED_SLOW = 1'b0;
    localparam logic SPEED_FAST = 1'b1;

endpackage

// File: rtl/led_speed_ctrl_if.sv
// Board-side signal bundle of the LED rate controller: speed input, run gate,
// shift-enable pulse and status.
interface led_speed_ctrl_if;

    logic sd_in;
    logic run;
    logic shift_en;
    logic speed_sel;
    logic pending;

    modport master (
        output sd_in,
        output run,
        input  shift_en,
        input  speed_sel,
        input  pending
    );

    modport slave (
        input  sd_in,
        input  run,
        output shift_en,
        output speed_sel,
        output pending
    );

endinterface

// File: rtl/led_speed_ctrl_sd_debounce.sv
// Two-flop synchronizer plus stable-level debouncer; sd_db only moves after
// the synchronized input has differed from it for DB_CYCLES consecutive cycles.
module sd_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sd_in,
    output logic sd_db
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          sd_db_q;
    logic          sd_db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d   = '0;
        sd_db_d = sd_db_q;
        if (sync2_q != sd_db_q) begin
            // Accept on the DB_CYCLES-th differing sample; counter falls back to 0.
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                sd_db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sd_db_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sd_in;
            sync2_q <= sync1_q;
            sd_db_q <= sd_db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sd_db = sd_db_q;

endmodule

// File: rtl/led_speed_ctrl.sv
// Single-clock shift-enable generator with fast/slow rate applied only on period
// boundaries. Define LED_SPEED_TOGGLE_EN to treat sd_in as a toggling pushbutton.
module led_speed_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned FAST_DIV  = 5_000_000,
    parameter int unsigned SLOW_MULT = 12,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    led_speed_ctrl_if.slave  bus
);

    localparam int unsigned SLOW_DIV = FAST_DIV * SLOW_MULT;
    localparam int unsigned CW       = $clog2(SLOW_DIV);

    logic          sd_db;
    logic          req;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] last;
    logic          wrap;
    logic          shift_en_q;
    logic          shift_en_d;
    logic          speed_q;
    logic          speed_d;
    logic          pending_q;
    logic          pending_d;

    sd_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_sd_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .sd_in (bus.sd_in),
        .sd_db (sd_db)
    );

`ifdef LED_SPEED_TOGGLE_EN
    logic req_q;
    logic req_d;
    logic sd_db_prev_q;

    always_comb begin
        req_d = req_q;
        if (sd_db && !sd_db_prev_q) begin
            req_d = ~req_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= 1'b0;
            sd_db_prev_q <= 1'b0;
        end else begin
            req_q        <= req_d;
            sd_db_prev_q <= sd_db;
        end
    end

    assign req = req_q;
`else
    assign req = sd_db;
`endif

    assign last = (speed_q == SPEED_FAST) ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);
    assign wrap = (cnt_q == last);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_en_d = 1'b0;
        speed_d    = speed_q;
        pending_d  = pending_q;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                pending_d = 1'b0;
                speed_d   = req;
                if (bus.run) begin
                    state_d = RUN;
                end
            end
            RUN, PEND: begin
                if (!bus.run) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
                    shift_en_d = wrap;
                    // A change seen on a wrap cycle waits a full period at the old rate.
                    if (state_q == RUN) begin
                        if (req != speed_q) begin
                            state_d   = PEND;
                            pending_d = 1'b1;
                        end
                    end else if (wrap) begin
                        speed_d   = req;
                        pending_d = 1'b0;
                        state_d   = RUN;
                    end else if (req == speed_q) begin
                        pending_d = 1'b0;
                        state_d   = RUN;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_en_q <= 1'b0;
            speed_q    <= SPEED_SLOW;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_en_q <= shift_en_d;
            speed_q    <= speed_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.shift_en  = shift_en_q;
    assign bus.speed_sel = speed_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_led_speed_ctrl.sv
// Self-checking bench for led_speed_ctrl: directed timing checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_led_speed_ctrl;

    localparam int FD = 4;
    localparam int SM = 3;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    led_speed_ctrl_if bus ();

    led_speed_ctrl #(
        .FAST_DIV  (FD),
        .SLOW_MULT (SM),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: raw input history, period position, and rate flags.
    bit m_hist[$];
    bit m_db, m_db_prev, m_req, m_running, m_pend, m_speed, m_pulse;
    int m_elapsed;

    always @(posedge clk or negedge rst_n) begin : model
        bit req_now, all_diff, old_db;
        int div;
        if (!rst_n) begin
            m_hist.delete();
            for (int i = 0; i < DB + 2; i++) m_hist.push_back(1'b0);
            m_db = 0; m_db_prev = 0; m_req = 0; m_running = 0;
            m_pend = 0; m_speed = 0; m_pulse = 0; m_elapsed = 0;
        end else begin
            req_now = m_req;
            if (!m_running) begin
                m_pulse = 0; m_pend = 0; m_elapsed = 0;
                m_speed = req_now;
                m_running = bus.run;
            end else if (!bus.run) begin
                m_running = 0; m_pulse = 0; m_pend = 0; m_elapsed = 0;
            end else begin
                div = m_speed ? FD : FD * SM;
                m_pulse = (m_elapsed == div - 1);
                m_elapsed = m_pulse ? 0 : m_elapsed + 1;
                if (m_pend) begin
                    if (m_pulse) begin
                        m_speed = req_now;
                        m_pend = 0;
                    end else if (req_now == m_speed) begin
                        m_pend = 0;
                    end
                end else if (req_now != m_speed) begin
                    m_pend = 1;
                end
            end
            // Accept a level once the input, seen through two sync stages,
            // has differed from the debounced value for DB consecutive cycles.
            m_hist.push_front(bus.sd_in);
            void'(m_hist.pop_back());
            all_diff = 1;
            for (int i = 2; i <= DB + 1; i++) if (m_hist[i] == m_db) all_diff = 0;
            old_db = m_db;
            if (all_diff) m_db = ~m_db;
`ifdef LED_SPEED_TOGGLE_EN
            if (old_db && !m_db_prev) m_req = ~m_req;
            m_db_prev = old_db;
`else
            m_req = m_db;
`endif
        end
    end

    always @(negedge clk) begin
        chk("shift_en", bus.shift_en, m_pulse);
        chk("speed_sel", bus.speed_sel, m_speed);
        chk("pending", bus.pending, m_pend);
    end

    function automatic logic sel(int which);
        case (which)
            0: return bus.shift_en;
            1: return bus.pending;
            default: return bus.speed_sel;
        endcase
    endfunction

    // Count rising clock edges until the selected output equals val (bounded).
    task automatic wait_for(input int which, input logic val, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sel(which) !== val && n < 200);
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_shift_en"}, bus.shift_en, 1'b0);
        chk({tag, "_speed_sel"}, bus.speed_sel, 1'b0);
        chk({tag, "_pending"}, bus.pending, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int n, seen, hold;
        rst_n = 1'b0;
        bus.sd_in = 1'b0;
        bus.run = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

`ifndef LED_SPEED_TOGGLE_EN
        @(negedge clk);
        bus.run = 1'b1;
        wait_for(0, 1'b1, n); chk_int("first_pulse_slow", n, 13);
        wait_for(0, 1'b1, n); chk_int("slow_period", n, 12);
        chk("slow_speed_sel", bus.speed_sel, 1'b0);

        @(negedge clk);
        bus.sd_in = 1'b1;
        wait_for(1, 1'b1, n); chk_int("pending_latency", n, 6);
        wait_for(2, 1'b1, n); chk_int("switch_at_slow_wrap", n, 6);
        chk("switch_pulse", bus.shift_en, 1'b1);
        chk("switch_pending_clear", bus.pending, 1'b0);
        wait_for(0, 1'b1, n); chk_int("fast_period_a", n, 4);
        wait_for(0, 1'b1, n); chk_int("fast_period_b", n, 4);

        @(negedge clk); bus.sd_in = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.sd_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.pending || !bus.speed_sel) seen = 1;
        end
        chk_int("glitch_ignored", seen, 0);

        wait_for(0, 1'b1, n);
        repeat (2) @(posedge clk);
        @(negedge clk); bus.sd_in = 1'b0;
        wait_for(1, 1'b1, n); chk_int("wrap_change_pending", n, 6);
        chk("wrap_change_old_rate_pulse", bus.shift_en, 1'b1);
        wait_for(2, 1'b0, n); chk_int("wrap_change_switch", n, 4);
        chk("wrap_change_switch_pulse", bus.shift_en, 1'b1);
        wait_for(0, 1'b1, n); chk_int("slow_after_switch", n, 12);

        repeat (7) @(posedge clk);
        @(negedge clk); bus.run = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.shift_en || bus.pending) seen = 1;
        end
        chk_int("run_drop_no_pulse", seen, 0);
        @(negedge clk); bus.sd_in = 1'b1;
        wait_for(2, 1'b1, n); chk_int("idle_speed_follow", n, 6);
        @(negedge clk); bus.run = 1'b1;
        wait_for(0, 1'b1, n); chk_int("first_pulse_fast", n, 5);
`else
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            bus.sd_in = 1'b1;
            repeat (8) @(negedge clk);
            bus.sd_in = 1'b0;
            repeat (12) @(negedge clk);
            chk("toggle_speed", bus.speed_sel, (p == 0) ? 1'b1 : 1'b0);
        end
        bus.run = 1'b1;
`endif

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                bus.sd_in = ($urandom_range(0, 1) != 0);
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            if (bus.run) begin
                if ($urandom_range(0, 59) == 0) bus.run = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.run = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_zero_outputs("rand_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Reset asserted while a rate change is pending.
        @(negedge clk);
        bus.run = 1'b1;
        bus.sd_in = 1'b0;
        repeat (20) @(negedge clk);
`ifdef LED_SPEED_TOGGLE_EN
        bus.sd_in = 1'b1;
        repeat (6) @(negedge clk);
        bus.sd_in = 1'b0;
`else
        bus.sd_in = ~bus.speed_sel;
`endif
        wait_for(1, 1'b1, n);
        chk("pend_before_reset", bus.pending, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("pend_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
